// File: rtl/ccw_fetch.sv
// ccw_fetch: channel command word fetch/decode sequencer for the RH20/DMA20 channel.
//   Fetches CCWs through a req/ack memory port, follows jumps, and hands each
//   data-transfer CCW to the channel control stage as a descriptor.
//   Ports:
//     clk_ccw_h, crc_reset_l                 clock, async active-low reset
//     ch_start_h, ch_start_adr               start pulse and initial CCW address
//     ch_reset_intr_h                        synchronous abort to IDLE
//     ccw_mem_req_h/adr, ccw_mem_ack_h/err_h/data   CCW read port
//     ccw_ccwf_waiting_h, ccw_xfer_*         descriptor to control stage
//     ccl_ccwf_clr_h                         descriptor consumed
//     ccw_halt_h, ccw_err_h                  program ended normally / in error
//   Optional: define CCW_JUMP_LIMIT_EN to fault the 4th consecutive JUMP.
module ccw_fetch #(
   parameter int ADR_W = 22,
   parameter int WC_W  = 11
) (
   input  logic             clk_ccw_h,
   input  logic             crc_reset_l,
   input  logic             ch_start_h,
   input  logic [ADR_W-1:0] ch_start_adr,
   input  logic             ch_reset_intr_h,
   output logic             ccw_mem_req_h,
   output logic [ADR_W-1:0] ccw_mem_adr,
   input  logic             ccw_mem_ack_h,
   input  logic             ccw_mem_err_h,
   input  logic [35:0]      ccw_mem_data,
   output logic             ccw_ccwf_waiting_h,
   output logic [ADR_W-1:0] ccw_xfer_adr,
   output logic [WC_W-1:0]  ccw_xfer_wc,
   output logic             ccw_xfer_last_h,
   output logic             ccw_xfer_rev_h,
   input  logic             ccl_ccwf_clr_h,
   output logic             ccw_halt_h,
   output logic             ccw_err_h
);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_XFER, S_HALT, S_ERR} state_t;
   state_t           state_q, state_d;
   logic [ADR_W-1:0] ptr_q, ptr_d, xadr_q, xadr_d;
   logic [WC_W-1:0]  xwc_q, xwc_d;
   logic             xlast_q, xlast_d, xrev_q, xrev_d;
   logic             req_q, req_d, wait_q, wait_d, halt_q, halt_d, err_q, err_d;
   logic             start_ok, ack_ok, is_data, is_jump, jump_stop;
   logic [WC_W-1:0]  f_wc;
   logic [ADR_W-1:0] f_adr;
   // PDP-10 bit numbering: CCW bit k lives at ccw_mem_data[35-k]
   assign is_data  = ccw_mem_data[35];
   assign is_jump  = ~ccw_mem_data[35] & ccw_mem_data[34];
   assign f_wc     = ccw_mem_data[32 -: WC_W];
   assign f_adr    = ccw_mem_data[ADR_W-1:0];
   assign start_ok = ch_start_h & ((state_q == S_IDLE) | (state_q == S_HALT));
   assign ack_ok   = (state_q == S_FETCH) & ccw_mem_ack_h & ~ccw_mem_err_h;
`ifdef CCW_JUMP_LIMIT_EN
   logic [2:0] jcnt_q, jcnt_d;
   assign jump_stop = (jcnt_q == 3'd3);
   always_comb
      jcnt_d = (ch_reset_intr_h | start_ok) ? 3'd0 :
               ack_ok ? (is_jump ? jcnt_q + 3'd1 : 3'd0) : jcnt_q;
   always_ff @(posedge clk_ccw_h or negedge crc_reset_l)
      if (!crc_reset_l) jcnt_q <= 3'd0;
      else              jcnt_q <= jcnt_d;
`else
   assign jump_stop = 1'b0;
`endif
   always_ff @(posedge clk_ccw_h or negedge crc_reset_l)
      if (!crc_reset_l) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         xadr_q  <= '0;
         xwc_q   <= '0;
         xlast_q <= 1'b0;
         xrev_q  <= 1'b0;
         req_q   <= 1'b0;
         wait_q  <= 1'b0;
         halt_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         xadr_q  <= xadr_d;
         xwc_q   <= xwc_d;
         xlast_q <= xlast_d;
         xrev_q  <= xrev_d;
         req_q   <= req_d;
         wait_q  <= wait_d;
         halt_q  <= halt_d;
         err_q   <= err_d;
      end
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      xadr_d  = xadr_q;
      xwc_d   = xwc_q;
      xlast_d = xlast_q;
      xrev_d  = xrev_q;
      case (state_q)
         S_IDLE, S_HALT:
            if (ch_start_h) begin
               ptr_d   = ch_start_adr;
               state_d = S_FETCH;
            end
         S_FETCH:
            if (ccw_mem_ack_h) begin
               if (ccw_mem_err_h) state_d = S_ERR;
               else if (is_jump) begin
                  // a faulted jump leaves the pointer on the JUMP itself
                  if (jump_stop) state_d = S_ERR;
                  else           ptr_d   = f_adr;
               end else if (!is_data) state_d = S_HALT;
               else begin
                  ptr_d = ptr_q + ADR_W'(1);
                  if (f_wc != '0) begin
                     xadr_d  = f_adr;
                     xwc_d   = f_wc;
                     xlast_d = ccw_mem_data[34];
                     xrev_d  = ccw_mem_data[33];
                     state_d = S_XFER;
                  end else state_d = ccw_mem_data[34] ? S_HALT : S_FETCH;
               end
            end
         S_XFER:
            if (ccl_ccwf_clr_h) state_d = xlast_q ? S_HALT : S_FETCH;
         default: state_d = state_q;
      endcase
      if (ch_reset_intr_h) begin
         state_d = S_IDLE;
         ptr_d   = '0;
         xadr_d  = '0;
         xwc_d   = '0;
         xlast_d = 1'b0;
         xrev_d  = 1'b0;
      end
   end
   always_comb begin
      req_d  = (state_d == S_FETCH);
      wait_d = (state_d == S_XFER);
      halt_d = (state_d == S_HALT);
      err_d  = (state_d == S_ERR);
   end
   assign ccw_mem_req_h      = req_q;
   assign ccw_mem_adr        = ptr_q;
   assign ccw_ccwf_waiting_h = wait_q;
   assign ccw_xfer_adr       = xadr_q;
   assign ccw_xfer_wc        = xwc_q;
   assign ccw_xfer_last_h    = xlast_q;
   assign ccw_xfer_rev_h     = xrev_q;
   assign ccw_halt_h         = halt_q;
   assign ccw_err_h          = err_q;
endmodule

// File: tb/tb_ccw_fetch.sv
// tb_ccw_fetch: directed self-checking bench for ccw_fetch.
module tb_ccw_fetch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [21:0] start_adr = '0;
   logic        rintr = 1'b0;
   logic        req;
   logic [21:0] madr;
   logic        ack = 1'b0;
   logic        merr = 1'b0;
   logic [35:0] mdata = '0;
   logic        waiting;
   logic [21:0] xadr;
   logic [10:0] xwc;
   logic        xlast, xrev;
   logic        clr = 1'b0;
   logic        halt, err;
   int          n_tests = 0;
   int          n_fail = 0;
   ccw_fetch dut (
      .clk_ccw_h(clk), .crc_reset_l(rst_n), .ch_start_h(start), .ch_start_adr(start_adr),
      .ch_reset_intr_h(rintr), .ccw_mem_req_h(req), .ccw_mem_adr(madr),
      .ccw_mem_ack_h(ack), .ccw_mem_err_h(merr), .ccw_mem_data(mdata),
      .ccw_ccwf_waiting_h(waiting), .ccw_xfer_adr(xadr), .ccw_xfer_wc(xwc),
      .ccw_xfer_last_h(xlast), .ccw_xfer_rev_h(xrev), .ccl_ccwf_clr_h(clr),
      .ccw_halt_h(halt), .ccw_err_h(err)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0o expected %0o", tag, got, exp);
      end
   endtask
   function automatic logic [35:0] dccw(input logic last, input logic rev, input logic [10:0] wc, input logic [21:0] a);
      return {1'b1, last, rev, wc, a};
   endfunction
   function automatic logic [35:0] jccw(input logic [21:0] a);
      return {2'b01, 12'd0, a};
   endfunction
   task automatic step();
      @(negedge clk);
   endtask
   task automatic do_start(input logic [21:0] a);
      start = 1'b1; start_adr = a;
      step();
      start = 1'b0;
   endtask
   task automatic do_ack(input logic [35:0] d, input logic e);
      ack = 1'b1; mdata = d; merr = e;
      step();
      ack = 1'b0; merr = 1'b0; mdata = '0;
   endtask
   task automatic do_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask
   task automatic do_rintr();
      rintr = 1'b1;
      step();
      rintr = 1'b0;
   endtask
   initial begin
      step(); step();
      check("rst_req", req, 0);
      check("rst_adr", madr, 0);
      check("rst_flags", {waiting, halt, err, xlast, xrev}, 0);
      check("rst_desc", {xadr, xwc}, 0);
      rst_n = 1'b1;
      step();
      // single last data CCW
      do_start(22'o1000);
      check("t1_req", req, 1);
      check("t1_adr", madr, 22'o1000);
      do_ack(dccw(1'b1, 1'b0, 11'd5, 22'o20000), 1'b0);
      check("t1_wait", {waiting, req}, 2'b10);
      check("t1_desc", {xadr, xwc, xlast, xrev}, {22'o20000, 11'd5, 1'b1, 1'b0});
      step(); step();
      check("t1_hold", {waiting, xwc}, {1'b1, 11'd5});
      do_clr();
      check("t1_halt", {halt, waiting, req}, 3'b100);
      step(); step();
      check("t1_noreq", req, 0);
      // jump chain from HALT
      do_start(22'o100);
      check("t2_req", {req, halt}, 2'b10);
      check("t2_adr0", madr, 22'o100);
      do_ack(jccw(22'o200), 1'b0);
      check("t2_jump", {req, madr}, {1'b1, 22'o200});
      do_ack(dccw(1'b0, 1'b0, 11'd3, 22'o300), 1'b0);
      check("t2_desc", {waiting, req, xwc, xlast}, {1'b1, 1'b0, 11'd3, 1'b0});
      do_clr();
      check("t2_next", {waiting, req, madr}, {1'b0, 1'b1, 22'o201});
      do_ack(36'd0, 1'b0);
      check("t2_halt", {halt, req}, 2'b10);
      // WC=0 no-op
      do_start(22'o500);
      do_ack(dccw(1'b0, 1'b0, 11'd0, 22'o777), 1'b0);
      check("t3_noop", {waiting, req, madr}, {1'b0, 1'b1, 22'o501});
      do_ack(dccw(1'b1, 1'b1, 11'd2, 22'o4000), 1'b0);
      check("t3_desc", {waiting, xwc, xlast, xrev, xadr}, {1'b1, 11'd2, 1'b1, 1'b1, 22'o4000});
      do_clr();
      check("t3_halt", halt, 1);
      do_start(22'o600);
      do_ack(dccw(1'b1, 1'b0, 11'd0, 22'o1), 1'b0);
      check("t3_wc0_last", {halt, waiting, req}, 3'b100);
      // pointer wrap
      do_start(22'o17777777);
      do_ack(dccw(1'b0, 1'b0, 11'd1, 22'o1), 1'b0);
      do_clr();
      check("t4_wrap", {req, madr}, {1'b1, 22'd0});
      do_rintr();
      check("t4_rintr", {req, madr, waiting, halt, err}, 0);
      // clr and ack outside their states are ignored
      clr = 1'b1; ack = 1'b1;
      step();
      clr = 1'b0; ack = 1'b0;
      check("t4_ign", {req, waiting, halt, err}, 0);
      // memory error on second fetch
      do_start(22'o700);
      do_ack(dccw(1'b0, 1'b0, 11'd1, 22'o10), 1'b0);
      do_clr();
      check("t5_adr", madr, 22'o701);
      do_ack(36'd0, 1'b1);
      check("t5_err", {err, halt, req, waiting}, 4'b1000);
      check("t5_ptr", madr, 22'o701);
      do_start(22'o1234);
      check("t5_nostart", {err, req, madr}, {1'b1, 1'b0, 22'o701});
      do_rintr();
      check("t5_clear", {err, req, madr}, 0);
      // abort coincident with ack
      do_start(22'o40);
      rintr = 1'b1;
      do_ack(dccw(1'b0, 1'b0, 11'd7, 22'o55), 1'b0);
      rintr = 1'b0;
      check("t6_abort", {req, waiting, halt, err, madr, xwc, xadr}, 0);
      step();
      check("t6_idle", {req, waiting}, 0);
      // four consecutive jumps
      do_start(22'o10);
      do_ack(jccw(22'o11), 1'b0);
      do_ack(jccw(22'o12), 1'b0);
      do_ack(jccw(22'o13), 1'b0);
      check("t7_third", {req, madr}, {1'b1, 22'o13});
      do_ack(jccw(22'o14), 1'b0);
`ifdef CCW_JUMP_LIMIT_EN
      check("t7_limit", {err, req, madr}, {1'b1, 1'b0, 22'o13});
`else
      check("t7_follow", {err, req, madr}, {1'b0, 1'b1, 22'o14});
      do_ack(36'd0, 1'b0);
      check("t7_halt", halt, 1);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ccw_fetch.md
# ccw_fetch

Channel command word fetch and decode sequencer for the RH20/DMA20 channel. It fetches CCWs from memory through a request/acknowledge port and follows jumps. Each data-transfer CCW is presented as a descriptor to the channel control stage directly downstream, which asserts `ccl_ccwf_clr_h` when that transfer is finished. The block produces `ccw_ccwf_waiting_h`, the flag the control stage consumes.

## Interface
Parameters:
- `ADR_W`, 22, CCW and data address width
- `WC_W`, 11, CCW word-count field width

Ports:
- `clk_ccw_h`  in  1  channel clock, rising edge
- `crc_reset_l`  in  1  asynchronous active-low reset
- `ch_start_h`  in  1  one-cycle start pulse; ignored unless IDLE or HALT
- `ch_start_adr`  in  ADR_W  initial CCW address, sampled with `ch_start_h`
- `ch_reset_intr_h`  in  1  synchronous abort to IDLE, wins over every other input
- `ccw_mem_req_h`  out  1  CCW read request
- `ccw_mem_adr`  out  ADR_W  CCW read address
- `ccw_mem_ack_h`  in  1  read done; `ccw_mem_data` is valid in the same cycle
- `ccw_mem_err_h`  in  1  read failed; qualified by `ccw_mem_ack_h`
- `ccw_mem_data`  in  36  CCW word, bit 0 = MSB (PDP-10 order)
- `ccw_ccwf_waiting_h`  out  1  descriptor valid, waiting for downstream
- `ccw_xfer_adr`  out  ADR_W  data address of the current descriptor
- `ccw_xfer_wc`  out  WC_W  word count of the current descriptor
- `ccw_xfer_last_h`  out  1  current descriptor is the last transfer
- `ccw_xfer_rev_h`  out  1  reverse-direction transfer
- `ccl_ccwf_clr_h`  in  1  downstream has consumed the descriptor
- `ccw_halt_h`  out  1  channel program ended normally
- `ccw_err_h`  out  1  channel program ended in error

## Operation
CCW decode rules:
- Bit 0 = 1 marks a data transfer. Bit 1 = last, bit 2 = reverse, bits 3-13 = WC, bits 14-35 = address.
- Bit 0 = 0 with bit 1 = 0 is HALT.
- Bit 0 = 0 with bit 1 = 1 is JUMP; the target is bits 14-35.

States:
- IDLE:
  - `ch_start_h` loads the CCW pointer from `ch_start_adr` and clears `ccw_halt_h` and `ccw_err_h` → FETCH.
- FETCH:
  - Asserts `ccw_mem_req_h` with `ccw_mem_adr` = pointer.
  - Request and address stay stable until ack.
  - On ack with err → ERR.
  - On ack without err, decode:
    - HALT → HALT.
    - JUMP → pointer = target, stay in FETCH, request stays asserted.
    - Data transfer, WC≠0 → latch descriptor, pointer+1 → XFER.
    - Data transfer, WC=0 → no-op, pointer+1. Goes to HALT if the last bit is set, otherwise stays in FETCH.
- XFER:
  - `ccw_ccwf_waiting_h`=1; descriptor outputs held stable.
  - On `ccl_ccwf_clr_h`: go to HALT if last, otherwise FETCH.
- HALT: `ccw_halt_h`=1; accepts `ch_start_h` like IDLE.
- ERR:
  - `ccw_err_h`=1; the pointer keeps the failing address.
  - Only `ch_reset_intr_h` or reset exits ERR.
- Pointer increment wraps modulo 2^ADR_W (all-ones → 0).
- `ch_reset_intr_h` from any state:
  - Next state IDLE; all outputs go to 0 at that edge.
  - An outstanding request is dropped, and an ack in the same cycle is ignored.
- `ccl_ccwf_clr_h` outside XFER is ignored. `ccw_mem_ack_h` outside FETCH is ignored.

## Timing
- Reset: state IDLE; every output and every internal register is 0.
- `ch_start_h` at edge N → `ccw_mem_req_h`=1 from cycle N+1.
- Ack at edge M, data transfer → `ccw_ccwf_waiting_h`=1 from cycle M+1.
- Ack at edge M, JUMP → request stays high with the new address from cycle M+1. There is no one-cycle gap.
- `ccl_ccwf_clr_h` at edge K (not last) → waiting=0 and request=1 from cycle K+1.
- Minimum spacing between fetches is one cycle per CCW.
- All outputs are registered.

## Configuration
- `CCW_JUMP_LIMIT_EN` defined:
  - A 3-bit counter counts consecutive JUMPs. It clears on any non-JUMP decode and on start.
  - The 4th consecutive JUMP goes to ERR instead of following the jump; the pointer holds that JUMP's address.
- `CCW_JUMP_LIMIT_EN` undefined: no counter; jumps are followed indefinitely.

## Test plan
- Start at 0o1000. Memory holds a data CCW (last=1, WC=5, adr 0o20000) followed by nothing. Expected:
  - One fetch at 0o1000.
  - Waiting=1 with wc=5, adr=0o20000, last=1.
  - After clr, `ccw_halt_h`=1 and no further request.
- Start at 0o100 → JUMP 0o200 → data CCW (WC=3, last=0) → HALT. Expected:
  - Fetch addresses 0o100, 0o200, 0o201, with request held continuously across the jump.
  - Halt after clr.
- Data CCW with WC=0, last=0, at 0o500, followed by data CCW WC=2, last=1. Expected:
  - No waiting for the first CCW.
  - Descriptor wc=2 from 0o501.
- Start at 0o17777777 (all ones): the CCW there is a data transfer, not last. Expected:
  - After clr, the next fetch is at address 0.
- Ack with `ccw_mem_err_h` on the second fetch. Expected:
  - `ccw_err_h`=1 and the pointer holds the failing address.
  - `ch_start_h` is ignored.
  - `ch_reset_intr_h` clears to IDLE.
- `ch_reset_intr_h` coincident with ack in FETCH. Expected:
  - Next cycle IDLE, all outputs 0, data discarded.
- With `CCW_JUMP_LIMIT_EN`, a chain of 4 JUMPs starting at 0o10 produces ERR at the 4th JUMP (address 0o13 if sequential). Without the macro, the chain is followed.
